iter_mult_radix: RTL and testbench



---
 rtl/mult_pkg.sv | 20 ++
 rtl/mult_digit_pp.sv | 20 ++
 rtl/iter_mult_radix.sv | 160 ++++++++++++++++
 tb/tb_iter_mult_radix.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and elaboration helpers for the iterative radix-2^DIGIT multiplier.
package mult_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mult_state_t;

  // Number of digit iterations needed to retire a full-width multiplier operand.
  function automatic int unsigned iter_limit(input int unsigned width, input int unsigned digit);
    return width / digit;
  endfunction

  // Legal configuration: radix 2, 4, 16 or 256 and a whole number of digits per operand.
  function automatic bit cfg_ok(input int unsigned width, input int unsigned digit);
    return ((digit == 1) || (digit == 2) || (digit == 4) || (digit == 8)) &&
           (width >= digit) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/mult_digit_pp.sv
// One DIGIT x 2*WIDTH partial product, kept separate so Booth recoding can drop in later.
module mult_digit_pp
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIGIT = 4
) (
  input  logic [DIGIT-1:0]   digit,
  input  logic [2*WIDTH-1:0] mc,
  output logic [2*WIDTH-1:0] pp_c
);

  localparam int unsigned PW = 2 * WIDTH;

  // Product truncated to the accumulator width; the full product never exceeds it.
  always_comb begin
    pp_c = PW'(digit) * mc;
  end

endmodule

// File: rtl/iter_mult_radix.sv
// Iterative multiplier: retires DIGIT bits of operand a per cycle into a 2*WIDTH product,
// stopping early once the remaining multiplier bits are all zero.
// Optional signed mode is compiled in with `define MULT_SIGNED_EN (adds signed_in port).
module iter_mult_radix
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIGIT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               valid_in,
  output logic               ready_in,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
`ifdef MULT_SIGNED_EN
  input  logic               signed_in,
`endif
  output logic               valid_out,
  output logic [2*WIDTH-1:0] r,
  output logic               busy
);

  localparam int unsigned PW     = 2 * WIDTH;
  localparam int unsigned N_ITER = iter_limit(WIDTH, DIGIT);
  localparam int unsigned CNT_W  = (N_ITER > 1) ? $clog2(N_ITER) : 1;

  if (!cfg_ok(WIDTH, DIGIT)) begin : g_cfg_err
    $error("iter_mult_radix: WIDTH must be a multiple of DIGIT, DIGIT in {1,2,4,8}");
  end

  mult_state_t      state_q, state_d;
  logic [WIDTH-1:0] mp_q, mp_d;
  logic [PW-1:0]    mc_q, mc_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic [PW-1:0]    r_q, r_d;
  logic             valid_q, valid_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] a_mag_c;
  logic [WIDTH-1:0] b_mag_c;
  logic             neg_in_c;
  logic [PW-1:0]    pp_c;
  logic             last_c;

  // Operand magnitudes and product sign captured at accept.
`ifdef MULT_SIGNED_EN
  always_comb begin
    a_mag_c  = (signed_in && a[WIDTH-1]) ? (WIDTH'(0) - a) : a;
    b_mag_c  = (signed_in && b[WIDTH-1]) ? (WIDTH'(0) - b) : b;
    neg_in_c = signed_in && (a[WIDTH-1] ^ b[WIDTH-1]);
  end
`else
  always_comb begin
    a_mag_c  = a;
    b_mag_c  = b;
    neg_in_c = 1'b0;
  end
`endif

  mult_digit_pp #(
    .WIDTH (WIDTH),
    .DIGIT (DIGIT)
  ) u_pp (
    .digit (mp_q[DIGIT-1:0]),
    .mc    (mc_q),
    .pp_c  (pp_c)
  );

  // Final iteration: no multiplier bits left above this digit, or the last digit slot.
  assign last_c = ((mp_q >> DIGIT) == '0) || (cnt_q == CNT_W'(N_ITER - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (valid_in) state_d = RUN;
      RUN:     if (last_c)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    mp_d    = mp_q;
    mc_d    = mc_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    r_d     = r_q;
    valid_d = 1'b0;
    ready_d = (state_d == IDLE);
    busy_d  = (state_d == RUN);
    unique case (state_q)
      IDLE: begin
        if (valid_in) begin
          mp_d  = a_mag_c;
          mc_d  = PW'(b_mag_c);
          acc_d = '0;
          cnt_d = '0;
          neg_d = neg_in_c;
        end
      end
      RUN: begin
        acc_d = acc_q + pp_c;
        mp_d  = mp_q >> DIGIT;
        mc_d  = mc_q << DIGIT;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_c) begin
          r_d     = neg_q ? (PW'(0) - acc_d) : acc_d;
          valid_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mp_q    <= '0;
      mc_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      r_q     <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      mp_q    <= mp_d;
      mc_q    <= mc_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      r_q     <= r_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign ready_in  = ready_q;
  assign busy      = busy_q;
  assign valid_out = valid_q;
  assign r         = r_q;

endmodule

// File: tb/tb_iter_mult_radix.sv
// Directed bench for iter_mult_radix (WIDTH=32, DIGIT=4); signed cases need MULT_SIGNED_EN.
module tb_iter_mult_radix;

  logic        clk;
  logic        rst_n;
  logic        valid_in;
  logic        ready_in;
  logic [31:0] a;
  logic [31:0] b;
`ifdef MULT_SIGNED_EN
  logic        signed_in;
`endif
  logic        valid_out;
  logic [63:0] r;
  logic        busy;

  int total;
  int bad;

  iter_mult_radix #(
    .WIDTH (32),
    .DIGIT (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .a         (a),
    .b         (b),
`ifdef MULT_SIGNED_EN
    .signed_in (signed_in),
`endif
    .valid_out (valid_out),
    .r         (r),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one operation from IDLE (called #1 after an edge) and check result and timing.
  task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                        input logic [63:0] exp_r, input int exp_it);
    int n;
    n = 0;
    a = av;
    b = bv;
    valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    check({tag, "_busy"}, 64'(busy), 64'd1);
    check({tag, "_rdy_low"}, 64'(ready_in), 64'd0);
    while (!valid_out && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_iters"}, 64'(n), 64'(exp_it));
    check({tag, "_r"}, r, exp_r);
    check({tag, "_rdy_done"}, 64'(ready_in), 64'd1);
    check({tag, "_busy_done"}, 64'(busy), 64'd0);
    @(posedge clk); #1;
    check({tag, "_vo_fall"}, 64'(valid_out), 64'd0);
    check({tag, "_r_hold"}, r, exp_r);
  endtask

  initial begin
    int n;
    total    = 0;
    bad      = 0;
    rst_n    = 1'b0;
    valid_in = 1'b0;
    a        = '0;
    b        = '0;
`ifdef MULT_SIGNED_EN
    signed_in = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 64'(ready_in), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_vo", 64'(valid_out), 64'd0);
    check("rst_r", r, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("6x7", 32'd6, 32'd7, 64'd42, 1);
    run_op("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 8);
    run_op("a0", 32'd0, 32'd123, 64'd0, 1);
    run_op("b0", 32'd123, 32'd0, 64'd0, 2);
    run_op("mid", 32'h0001_0000, 32'd3, 64'h0000_0000_0003_0000, 5);

    // Back-to-back: valid_in held; second accept lands on the first valid_out edge.
    a = 32'd3;
    b = 32'd5;
    valid_in = 1'b1;
    @(posedge clk); #1;
    n = 0;
    while (!valid_out && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("b2b_first_iters", 64'(n), 64'd1);
    check("b2b_first_r", r, 64'd15);
    check("b2b_first_rdy", 64'(ready_in), 64'd1);
    a = 32'd10;
    b = 32'd10;
    @(posedge clk); #1;
    valid_in = 1'b0;
    check("b2b_second_busy", 64'(busy), 64'd1);
    check("b2b_second_vo_low", 64'(valid_out), 64'd0);
    n = 0;
    while (!valid_out && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("b2b_second_iters", 64'(n), 64'd1);
    check("b2b_second_r", r, 64'd100);
    @(posedge clk); #1;

    // Reset asserted mid-operation aborts without a result.
    a = 32'h1234_5678;
    b = 32'd9;
    valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_ready", 64'(ready_in), 64'd1);
    check("abort_vo", 64'(valid_out), 64'd0);
    check("abort_r", r, 64'd0);
    n = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (valid_out) n++;
    end
    check("abort_no_vo", 64'(n), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("post_abort", 32'd2, 32'd3, 64'd6, 1);

`ifdef MULT_SIGNED_EN
    signed_in = 1'b1;
    run_op("s_neg3x5", 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, 1);
    run_op("s_minsq", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 8);
    signed_in = 1'b0;
    run_op("u_minsq", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 8);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
